// File: rtl/udp_pid_cmd.sv
// rtl/udp_pid_cmd.sv - 8-byte UDP command frame decoder driving the motor PID parameter bank
// Optional motor-enable watchdog: define UDP_PID_CMD_WDOG_EN.
module udp_pid_cmd #(
   parameter logic [7:0]  MAGIC       = 8'hA5,
   parameter logic [31:0] WDOG_CYCLES = 32'd27_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pay_vld,
   input  logic [7:0]  pay_byte,
   input  logic [15:0] pay_idx,
   input  logic        udp_done,
   input  logic [47:0] udp_src_mac,
   input  logic [31:0] udp_src_ip,
   input  logic [15:0] udp_src_port,
   output logic [31:0] setpoint,
   output logic [31:0] kp,
   output logic [31:0] ki,
   output logic [31:0] kd,
   output logic        motor_en,
   output logic        rep_req,
   output logic [7:0]  rep_status,
   output logic [7:0]  rep_addr,
   output logic [31:0] rep_data,
   output logic [47:0] rep_mac,
   output logic [31:0] rep_ip,
   output logic [15:0] rep_port
);

   typedef enum logic [1:0] {IDLE, CHECK, EXEC} state_t;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;

   state_t      state, next_state;
   logic [7:0]  stage [8];
   logic [3:0]  cnt;
   logic [7:0]  cmd [8];
   logic [3:0]  cmd_cnt;
   logic [47:0] cmd_mac;
   logic [31:0] cmd_ip;
   logic [15:0] cmd_port;

   logic        snap;
   logic        commit;
   logic [7:0]  csum;
   logic [7:0]  status;
   logic [31:0] cmd_data;
   logic [31:0] rd_val;
   logic [31:0] wr_val;
   logic        do_write;
   logic        wdog_trip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Commit (register write + reply latch) happens on the CHECK->EXEC edge,
   // so rep_req is high for exactly the EXEC cycle, two cycles after udp_done.
   always_comb begin
      next_state = state;
      snap       = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (udp_done) begin
               snap       = 1'b1;
               next_state = CHECK;
            end
         end
         CHECK: begin
            commit     = 1'b1;
            next_state = EXEC;
         end
         EXEC:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      csum     = cmd[0] ^ cmd[1] ^ cmd[2] ^ cmd[3] ^ cmd[4] ^ cmd[5] ^ cmd[6];
      cmd_data = {cmd[3], cmd[4], cmd[5], cmd[6]};
      status   = 8'd0;
      if (cmd_cnt < 4'd8)                              status = 8'd1;
      else if (cmd[0] != MAGIC)                        status = 8'd2;
      else if (csum != cmd[7])                         status = 8'd3;
      else if (cmd[1] != OP_WRITE && cmd[1] != OP_READ) status = 8'd4;
      else if (cmd[2] > 8'd4)                          status = 8'd5;
      do_write = (status == 8'd0) && (cmd[1] == OP_WRITE);
      case (cmd[2])
         8'd0:    rd_val = setpoint;
         8'd1:    rd_val = kp;
         8'd2:    rd_val = ki;
         8'd3:    rd_val = kd;
         8'd4:    rd_val = {31'd0, motor_en};
         default: rd_val = 32'd0;
      endcase
      wr_val = (cmd[2] == 8'd4) ? {31'd0, cmd_data[0]} : cmd_data;
   end

   // Snapshot clears the buffer, so bytes arriving in CHECK/EXEC start a fresh frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) stage[i] <= 8'd0;
         cnt <= 4'd0;
      end else if (snap) begin
         for (int i = 0; i < 8; i++) stage[i] <= 8'd0;
         cnt <= 4'd0;
      end else if (pay_vld) begin
         if (pay_idx < 16'd8) stage[pay_idx[2:0]] <= pay_byte;
         if (cnt != 4'hF)     cnt <= cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) cmd[i] <= 8'd0;
         cmd_cnt  <= 4'd0;
         cmd_mac  <= 48'd0;
         cmd_ip   <= 32'd0;
         cmd_port <= 16'd0;
      end else if (snap) begin
         for (int i = 0; i < 8; i++) cmd[i] <= stage[i];
         cmd_cnt  <= cnt;
         cmd_mac  <= udp_src_mac;
         cmd_ip   <= udp_src_ip;
         cmd_port <= udp_src_port;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         setpoint   <= 32'd0;
         kp         <= 32'd0;
         ki         <= 32'd0;
         kd         <= 32'd0;
         motor_en   <= 1'b0;
         rep_req    <= 1'b0;
         rep_status <= 8'd0;
         rep_addr   <= 8'd0;
         rep_data   <= 32'd0;
         rep_mac    <= 48'd0;
         rep_ip     <= 32'd0;
         rep_port   <= 16'd0;
      end else begin
         rep_req <= 1'b0;
         if (commit) begin
            rep_req    <= 1'b1;
            rep_status <= status;
            rep_addr   <= cmd[2];
            rep_mac    <= cmd_mac;
            rep_ip     <= cmd_ip;
            rep_port   <= cmd_port;
            if (status != 8'd0) rep_data <= 32'd0;
            else if (do_write)  rep_data <= wr_val;
            else                rep_data <= rd_val;
         end
         if (commit && do_write && cmd[2] == 8'd0) setpoint <= cmd_data;
         if (commit && do_write && cmd[2] == 8'd1) kp <= cmd_data;
         if (commit && do_write && cmd[2] == 8'd2) ki <= cmd_data;
         if (commit && do_write && cmd[2] == 8'd3) kd <= cmd_data;
         // An explicit enable write wins over a watchdog trip on the same edge.
         if (commit && do_write && cmd[2] == 8'd4) motor_en <= cmd_data[0];
         else if (wdog_trip)                       motor_en <= 1'b0;
      end
   end

`ifdef UDP_PID_CMD_WDOG_EN
   logic [31:0] wdog_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                wdog_cnt <= 32'd0;
      else if (commit && status == 8'd0)         wdog_cnt <= 32'd0;
      else if (wdog_cnt != 32'hFFFF_FFFF)        wdog_cnt <= wdog_cnt + 32'd1;
   end

   assign wdog_trip = motor_en && (wdog_cnt >= WDOG_CYCLES);
`else
   logic unused_cfg;
   assign unused_cfg = ^WDOG_CYCLES;
   assign wdog_trip  = 1'b0;
`endif

endmodule
